// File: rtl/key_gesture_decoder.sv
// key_gesture_decoder: classifies debounced press/release pulses into short, long and double-click pulses.
module key_gesture_decoder #(
  parameter int LONG_CYC = 12_000_000,
  parameter int DBL_CYC  = 3_600_000,
  parameter int CNT_W    = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_down,
  input  logic pb_up,
  output logic short_p,
  output logic long_p,
  output logic dbl_p,
  output logic busy,
  output logic led
);
  typedef enum logic [2:0] {IDLE, PRESS1, HOLD, WAIT2, PRESS2} state_t;
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_TC  = CNT_W'(DBL_CYC - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic short_q, short_d, long_q, long_d, dbl_q, dbl_d, busy_q, busy_d, led_q, led_d;
  logic dn, up;
  // Simultaneous press and release is illegal, so both are dropped for that cycle.
  assign dn = pb_down & ~pb_up;
  assign up = pb_up & ~pb_down;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      dbl_q   <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      dbl_q   <= dbl_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (dn) begin
        state_d = PRESS1;
        cnt_d   = '0;
      end
      PRESS1: if (up) begin
        state_d = WAIT2;
        cnt_d   = '0;
      end else if (cnt_q == LONG_TC) state_d = HOLD;
      else cnt_d = cnt_q + 1'b1;
      HOLD: if (up) state_d = IDLE;
      WAIT2: if (dn) state_d = PRESS2;
      else if (cnt_q == DBL_TC) state_d = IDLE;
      else cnt_d = cnt_q + 1'b1;
      PRESS2: if (up) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    short_d = (state_q == WAIT2) && !dn && (cnt_q == DBL_TC);
    long_d  = (state_q == PRESS1) && !up && (cnt_q == LONG_TC);
    dbl_d   = (state_q == PRESS2) && up;
    busy_d  = state_d != IDLE;
    led_d   = short_d ? ~led_q : long_d ? 1'b1 : dbl_d ? 1'b0 : led_q;
  end
  assign short_p = short_q;
  assign long_p  = long_q;
  assign dbl_p   = dbl_q;
  assign busy    = busy_q;
  assign led     = led_q;
endmodule

// File: tb/tb_key_gesture_decoder.sv
// tb_key_gesture_decoder: directed gesture vectors plus async-reset sequences for key_gesture_decoder.
module tb_key_gesture_decoder;
  logic clk, rst, pb_down, pb_up;
  logic short_p, long_p, dbl_p, busy, led;
  int compared = 0;
  int mismatched = 0;

  key_gesture_decoder #(.LONG_CYC(20), .DBL_CYC(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .pb_down(pb_down), .pb_up(pb_up),
    .short_p(short_p), .long_p(long_p), .dbl_p(dbl_p), .busy(busy), .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int dna, upa, dnb, upb, len;
    int exp_short, exp_long, exp_dbl, exp_np;
    int exp_busy0, exp_busy, exp_led;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    pb_down = 1'b0;
    pb_up = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v[8];
    int fs, fl, fd, np;
    // edges are counted from the first edge after reset release; -1 means never
    v[0] = '{0, 5, -1, -1, 16, 13, -1, -1, 1, 1, 0, 0};
    v[1] = '{0, 40, -1, -1, 42, -1, 20, -1, 1, 1, 0, 1};
    v[2] = '{0, 20, -1, -1, 30, 28, -1, -1, 1, 1, 0, 0};
    v[3] = '{0, 3, 11, 50, 52, -1, -1, 50, 1, 1, 0, 0};
    v[4] = '{0, 3, 12, -1, 12, 11, -1, -1, 1, 1, 1, 0};
    v[5] = '{0, 0, -1, -1, 5, -1, -1, -1, 0, 0, 0, 1};
    v[6] = '{1, 0, -1, 2, 12, 10, -1, -1, 1, 0, 0, 0};
    v[7] = '{0, 2, 10, 10, 12, 10, -1, -1, 1, 1, 0, 0};

    rst = 1'b0;
    pb_down = 1'b0;
    pb_up = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_led", int'(led), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pulses", int'({short_p, long_p, dbl_p}), 0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_reset();
      fs = -1; fl = -1; fd = -1; np = 0;
      for (int e = 0; e <= v[i].len; e++) begin
        pb_down = (e == v[i].dna) || (e == v[i].dnb);
        pb_up   = (e == v[i].upa) || (e == v[i].upb);
        @(posedge clk);
        #1;
        if (e == 0) chk($sformatf("vec%0d_busy0", i), int'(busy), v[i].exp_busy0);
        chk($sformatf("vec%0d_excl_e%0d", i, e), int'($countones({short_p, long_p, dbl_p}) <= 1), 1);
        if (short_p) begin if (fs < 0) fs = e; np++; end
        if (long_p)  begin if (fl < 0) fl = e; np++; end
        if (dbl_p)   begin if (fd < 0) fd = e; np++; end
      end
      pb_down = 1'b0;
      pb_up = 1'b0;
      chk($sformatf("vec%0d_short_edge", i), fs, v[i].exp_short);
      chk($sformatf("vec%0d_long_edge", i), fl, v[i].exp_long);
      chk($sformatf("vec%0d_dbl_edge", i), fd, v[i].exp_dbl);
      chk($sformatf("vec%0d_pulse_count", i), np, v[i].exp_np);
      chk($sformatf("vec%0d_busy_end", i), int'(busy), v[i].exp_busy);
      chk($sformatf("vec%0d_led_end", i), int'(led), v[i].exp_led);
    end

    // led is 0 here after the last short press; a mid-gesture reset must restore it asynchronously
    chk("pre_abort_led", int'(led), 0);
    pb_down = 1'b1;
    @(posedge clk);
    #1 pb_down = 1'b0;
    chk("abort_busy_before", int'(busy), 1);
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_busy_async", int'(busy), 0);
    chk("abort_led_async", int'(led), 1);
    chk("abort_pulses_async", int'({short_p, long_p, dbl_p}), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    np = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      np += int'(short_p) + int'(long_p) + int'(dbl_p);
    end
    chk("abort_no_pulse", np, 0);
    chk("abort_busy_after", int'(busy), 0);
    chk("abort_led_after", int'(led), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
